// File: rtl/udiv64_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : udiv64_ctrl_pkg
// Description : Shared encodings for the 64-bit divider GPIO sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package udiv64_ctrl_pkg;

    localparam int c_st_w = 3;

    localparam logic [c_st_w-1:0] c_st_idle  = 3'd0;
    localparam logic [c_st_w-1:0] c_st_load  = 3'd1;
    localparam logic [c_st_w-1:0] c_st_issue = 3'd2;
    localparam logic [c_st_w-1:0] c_st_wait  = 3'd3;
    localparam logic [c_st_w-1:0] c_st_done  = 3'd4;
    localparam logic [c_st_w-1:0] c_st_err   = 3'd5;

    typedef enum logic [c_st_w-1:0] {
        ST_IDLE  = c_st_idle,
        ST_LOAD  = c_st_load,
        ST_ISSUE = c_st_issue,
        ST_WAIT  = c_st_wait,
        ST_DONE  = c_st_done,
        ST_ERR   = c_st_err
    } state_t;

    // Bit positions inside ctrl_reg
    localparam int c_ctrl_wr    = 0;
    localparam int c_ctrl_start = 1;
    localparam int c_ctrl_abort = 2;
    localparam int c_ctrl_w     = 3;

    // Operand write locations (in_loc[1:0])
    localparam logic [1:0] c_loc_dvd_lo = 2'd0;
    localparam logic [1:0] c_loc_dvd_hi = 2'd1;
    localparam logic [1:0] c_loc_dvs_lo = 2'd2;
    localparam logic [1:0] c_loc_dvs_hi = 2'd3;

    // Result read locations (in_loc[3:2])
    localparam logic [1:0] c_loc_q_lo = 2'd0;
    localparam logic [1:0] c_loc_q_hi = 2'd1;
    localparam logic [1:0] c_loc_r_lo = 2'd2;
    localparam logic [1:0] c_loc_r_hi = 2'd3;

    // state_reg field positions
    localparam int c_sr_state_lsb = 0;
    localparam int c_sr_done      = 3;
    localparam int c_sr_dbz       = 4;
    localparam int c_sr_timeout   = 5;
    localparam int c_sr_wr_ign    = 6;
    localparam int c_sr_jobs_lsb  = 16;
    localparam int c_jobs_w       = 16;

endpackage
`default_nettype wire

// File: rtl/udiv64_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : udiv64_ctrl_if
// Description : GPIO register and divider-core signals of the sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface udiv64_ctrl_if #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 32
);
    logic [CHUNK-1:0] in_loc;
    logic [CHUNK-1:0] in_val;
    logic [CHUNK-1:0] ctrl_reg;
    logic [CHUNK-1:0] out_loc;
    logic [CHUNK-1:0] out_val;
    logic [CHUNK-1:0] state_reg;

    logic             div_start;
    logic             div_abort;
    logic [WIDTH-1:0] div_dividend;
    logic [WIDTH-1:0] div_divisor;
    logic             div_done;
    logic [WIDTH-1:0] div_quotient;
    logic [WIDTH-1:0] div_remainder;

    // Sequencer side
    modport slave (
        input  in_loc, in_val, ctrl_reg,
        input  div_done, div_quotient, div_remainder,
        output out_loc, out_val, state_reg,
        output div_start, div_abort, div_dividend, div_divisor
    );

    // MCS GPIO and divider-core side
    modport master (
        output in_loc, in_val, ctrl_reg,
        output div_done, div_quotient, div_remainder,
        input  out_loc, out_val, state_reg,
        input  div_start, div_abort, div_dividend, div_divisor
    );
endinterface
`default_nettype wire

// File: rtl/udiv64_ctrl_edge_det.sv
`default_nettype none
// ============================================================================
// Module      : gpio_edge_det
// Description : N-bit rising-edge detector for software-driven GPIO strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_edge_det #(
    parameter int N = 3
) (
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic [N-1:0] i_sig,
    output logic      [N-1:0] o_rise
);
    logic [N-1:0] r_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev <= '0;
        end else begin
            r_prev <= i_sig;
        end
    end

    assign o_rise = i_sig & ~r_prev;
endmodule
`default_nettype wire

// File: rtl/udiv64_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : udiv64_ctrl
// Description : Sequencer between MCS GPIO registers and the iterative
//               unsigned 64-bit divider core.
// Revision    : 1.0 - initial release
// ============================================================================
module udiv64_ctrl
    import udiv64_ctrl_pkg::*;
#(
    parameter int WIDTH       = 64,
    parameter int CHUNK       = 32,
    parameter int TIMEOUT_CYC = 256
) (
    input  wire logic    clk,
    input  wire logic    reset,
    udiv64_ctrl_if.slave bus
);
    localparam int                 c_tmr_w    = $clog2(TIMEOUT_CYC);
    localparam logic [c_tmr_w-1:0] c_tmr_last = c_tmr_w'(TIMEOUT_CYC - 1);

    logic [c_ctrl_w-1:0] w_rise;
    logic                w_wr_edge;
    logic                w_start_edge;
    logic                w_abort_edge;
    logic                w_busy;
    logic [CHUNK-1:0]    w_rd_chunk;
    logic [CHUNK-1:0]    w_state_word;

    state_t              r_state;
    logic [WIDTH-1:0]    r_dvd;
    logic [WIDTH-1:0]    r_dvs;
    logic [WIDTH-1:0]    r_q;
    logic [WIDTH-1:0]    r_r;
    logic                r_done;
    logic                r_dbz;
    logic                r_timeout;
    logic                r_wr_ign;
    logic [c_jobs_w-1:0] r_jobs;
    logic [c_tmr_w-1:0]  r_timer;
    logic                r_div_start;
    logic                r_div_abort;
    logic [CHUNK-1:0]    r_out_loc;
    logic [CHUNK-1:0]    r_out_val;

    gpio_edge_det #(
        .N (c_ctrl_w)
    ) u_edge_det (
        .clk    (clk),
        .rst    (reset),
        .i_sig  (bus.ctrl_reg[c_ctrl_w-1:0]),
        .o_rise (w_rise)
    );

    assign w_wr_edge    = w_rise[c_ctrl_wr];
    assign w_start_edge = w_rise[c_ctrl_start];
    assign w_abort_edge = w_rise[c_ctrl_abort];
    assign w_busy       = (r_state == ST_ISSUE) || (r_state == ST_WAIT);

    always_comb begin
        w_rd_chunk = '0;
        case (bus.in_loc[3:2])
            c_loc_q_lo: w_rd_chunk = r_q[CHUNK-1:0];
            c_loc_q_hi: w_rd_chunk = r_q[WIDTH-1 -: CHUNK];
            c_loc_r_lo: w_rd_chunk = r_r[CHUNK-1:0];
            c_loc_r_hi: w_rd_chunk = r_r[WIDTH-1 -: CHUNK];
            default:    w_rd_chunk = '0;
        endcase
    end

    always_comb begin
        w_state_word                                = '0;
        w_state_word[c_sr_state_lsb +: c_st_w]      = r_state;
        w_state_word[c_sr_done]                     = r_done;
        w_state_word[c_sr_dbz]                      = r_dbz;
        w_state_word[c_sr_timeout]                  = r_timeout;
        w_state_word[c_sr_wr_ign]                   = r_wr_ign;
        w_state_word[c_sr_jobs_lsb +: c_jobs_w]     = r_jobs;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_dvd       <= '0;
            r_dvs       <= '0;
            r_q         <= '0;
            r_r         <= '0;
            r_done      <= 1'b0;
            r_dbz       <= 1'b0;
            r_timeout   <= 1'b0;
            r_wr_ign    <= 1'b0;
            r_jobs      <= '0;
            r_timer     <= '0;
            r_div_start <= 1'b0;
            r_div_abort <= 1'b0;
            r_out_loc   <= '0;
            r_out_val   <= '0;
        end else begin
            r_div_start <= 1'b0;
            r_div_abort <= 1'b0;
            r_out_loc   <= {{(CHUNK-2){1'b0}}, bus.in_loc[3:2]};
            r_out_val   <= w_rd_chunk;

            if (w_abort_edge) begin
                // Only the core needs telling; operands and results survive.
                if (w_busy) begin
                    r_div_abort <= 1'b1;
                end
                r_timer <= '0;
                r_state <= ST_IDLE;
            end else begin
                case (r_state)
                    ST_ISSUE: begin
                        r_timer <= '0;
                        r_state <= ST_WAIT;
                    end

                    ST_WAIT: begin
                        if (bus.div_done) begin
                            r_q     <= bus.div_quotient;
                            r_r     <= bus.div_remainder;
                            r_done  <= 1'b1;
                            r_jobs  <= r_jobs + 1'b1;
                            r_state <= ST_DONE;
                        end else if (r_timer == c_tmr_last) begin
                            r_div_abort <= 1'b1;
                            r_timeout   <= 1'b1;
                            r_state     <= ST_ERR;
                        end else begin
                            r_timer <= r_timer + 1'b1;
                        end
                    end

                    default: begin
                        if (w_start_edge) begin
                            if (r_dvs == '0) begin
                                // Divide by zero is resolved here; the core never starts.
                                r_q     <= '1;
                                r_r     <= r_dvd;
                                r_dbz   <= 1'b1;
                                r_done  <= 1'b1;
                                r_jobs  <= r_jobs + 1'b1;
                                r_state <= ST_DONE;
                            end else begin
                                r_div_start <= 1'b1;
                                r_state     <= ST_ISSUE;
                            end
                        end else if (w_wr_edge) begin
                            case (bus.in_loc[1:0])
                                c_loc_dvd_lo: r_dvd[CHUNK-1:0]     <= bus.in_val;
                                c_loc_dvd_hi: r_dvd[WIDTH-1 -: CHUNK] <= bus.in_val;
                                c_loc_dvs_lo: r_dvs[CHUNK-1:0]     <= bus.in_val;
                                c_loc_dvs_hi: r_dvs[WIDTH-1 -: CHUNK] <= bus.in_val;
                                default:      r_dvd                <= r_dvd;
                            endcase
                            r_done    <= 1'b0;
                            r_dbz     <= 1'b0;
                            r_timeout <= 1'b0;
                            r_wr_ign  <= 1'b0;
                            r_state   <= ST_LOAD;
                        end
                    end
                endcase

                // Operands are frozen while the core runs.
                if (w_busy && (w_wr_edge || w_start_edge)) begin
                    r_wr_ign <= 1'b1;
                end
            end
        end
    end

    assign bus.div_start    = r_div_start;
    assign bus.div_abort    = r_div_abort;
    assign bus.div_dividend = r_dvd;
    assign bus.div_divisor  = r_dvs;
    assign bus.out_loc      = r_out_loc;
    assign bus.out_val      = r_out_val;
    assign bus.state_reg    = w_state_word;

endmodule
`default_nettype wire

// File: tb/tb_udiv64_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_udiv64_ctrl
// Description : Self-checking bench for udiv64_ctrl with a behavioural core.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_udiv64_ctrl;
    import udiv64_ctrl_pkg::*;

    localparam int WIDTH       = 64;
    localparam int CHUNK       = 32;
    localparam int TIMEOUT_CYC = 256;
    localparam int CORE_LAT    = 66;

    typedef struct {
        logic [WIDTH-1:0] dvd;
        logic [WIDTH-1:0] dvs;
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] r;
        logic             dbz;
    } vec_t;

    logic   clk         = 1'b0;
    logic   reset       = 1'b1;
    int     errors      = 0;
    int     checks      = 0;
    int     core_mode   = 0;   // 0 normal, 1 never done, 2 ignores abort
    int     starts_seen = 0;
    int     aborts_seen = 0;
    vec_t   vecs [5];
    vec_t   exp_q [$];

    udiv64_ctrl_if #(.WIDTH(WIDTH), .CHUNK(CHUNK)) bus ();

    udiv64_ctrl #(
        .WIDTH       (WIDTH),
        .CHUNK       (CHUNK),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin : pulse_monitor
        forever begin
            @(negedge clk);
            if (bus.div_start === 1'b1) starts_seen++;
            if (bus.div_abort === 1'b1) aborts_seen++;
        end
    end

    initial begin : core_model
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        int               cnt;
        bit               pending;
        a = '0; b = '0; cnt = 0; pending = 1'b0;
        bus.div_done      = 1'b0;
        bus.div_quotient  = '0;
        bus.div_remainder = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.div_done = 1'b0;
            if (reset) begin
                pending = 1'b0;
            end else if (bus.div_start) begin
                a = bus.div_dividend;
                b = bus.div_divisor;
                cnt = CORE_LAT;
                pending = 1'b1;
            end else if (pending) begin
                if (bus.div_abort && core_mode != 2) begin
                    pending = 1'b0;
                end else if (core_mode != 1) begin
                    cnt--;
                    if (cnt == 0) begin
                        bus.div_done      = 1'b1;
                        bus.div_quotient  = a / b;
                        bus.div_remainder = a % b;
                        pending = 1'b0;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_ctrl(input int bitpos);
        bus.ctrl_reg[bitpos] = 1'b1;
        tick();
        bus.ctrl_reg[bitpos] = 1'b0;
        tick();
    endtask

    task automatic write_chunk(input logic [1:0] loc, input logic [CHUNK-1:0] val);
        bus.in_loc = {30'd0, loc};
        bus.in_val = val;
        pulse_ctrl(c_ctrl_wr);
    endtask

    task automatic load(input logic [WIDTH-1:0] dvd, input logic [WIDTH-1:0] dvs);
        write_chunk(c_loc_dvd_lo, dvd[31:0]);
        write_chunk(c_loc_dvd_hi, dvd[63:32]);
        write_chunk(c_loc_dvs_lo, dvs[31:0]);
        write_chunk(c_loc_dvs_hi, dvs[63:32]);
    endtask

    task automatic read_chunk(input logic [1:0] sel, output logic [CHUNK-1:0] val);
        bus.in_loc = {28'd0, sel, 2'b00};
        tick();
        check("out_loc", {32'd0, bus.out_loc}, {62'd0, sel});
        val = bus.out_val;
    endtask

    task automatic read_result(output logic [WIDTH-1:0] q, output logic [WIDTH-1:0] r);
        logic [CHUNK-1:0] c0, c1, c2, c3;
        read_chunk(c_loc_q_lo, c0);
        read_chunk(c_loc_q_hi, c1);
        read_chunk(c_loc_r_lo, c2);
        read_chunk(c_loc_r_hi, c3);
        q = {c1, c0};
        r = {c3, c2};
    endtask

    task automatic wait_state(input logic [2:0] target, input int budget, input string name);
        int n = 0;
        while (bus.state_reg[2:0] !== target && n < budget) begin
            tick();
            n++;
        end
        check(name, {61'd0, bus.state_reg[2:0]}, {61'd0, target});
    endtask

    // Pops the scoreboard once the DUT reports DONE and checks the job.
    task automatic run_job(input vec_t v, input int exp_jobs, input string tag);
        vec_t             e;
        logic [WIDTH-1:0] q, r;
        int               st0;
        load(v.dvd, v.dvs);
        st0 = starts_seen;
        exp_q.push_back(v);
        pulse_ctrl(c_ctrl_start);
        wait_state(c_st_done, 200, {tag, "_state"});
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_scoreboard: got empty queue expected 1 entry", tag);
        end else begin
            e = exp_q.pop_front();
            read_result(q, r);
            check({tag, "_q"}, q, e.q);
            check({tag, "_r"}, r, e.r);
            check({tag, "_dbz"}, {63'd0, bus.state_reg[c_sr_dbz]}, {63'd0, e.dbz});
            check({tag, "_done"}, {63'd0, bus.state_reg[c_sr_done]}, 64'd1);
            check({tag, "_jobs"}, {48'd0, bus.state_reg[31:16]}, exp_jobs);
            check({tag, "_starts"}, starts_seen - st0, e.dbz ? 64'd0 : 64'd1);
        end
    endtask

    initial begin : main
        logic [CHUNK-1:0] c;
        int               a0, st0, n;

        vecs[0] = '{dvd: 64'd100,               dvs: 64'd7,           q: 64'd14,         r: 64'd2,          dbz: 1'b0};
        vecs[1] = '{dvd: 64'h0000_0001_0000_0000, dvs: 64'h10,        q: 64'h1000_0000,  r: 64'd0,          dbz: 1'b0};
        vecs[2] = '{dvd: 64'd5,                 dvs: 64'd0,           q: '1,             r: 64'd5,          dbz: 1'b1};
        vecs[3] = '{dvd: 64'd7,                 dvs: 64'd100,         q: 64'd0,          r: 64'd7,          dbz: 1'b0};
        vecs[4] = '{dvd: 64'hFFFF_FFFF_FFFF_FFFF, dvs: 64'h1_0000_0000, q: 64'hFFFF_FFFF, r: 64'hFFFF_FFFF, dbz: 1'b0};

        bus.in_loc   = '0;
        bus.in_val   = '0;
        bus.ctrl_reg = '0;
        reset = 1'b1;
        tick(3);
        check("rst_state_reg", {32'd0, bus.state_reg}, 64'd0);
        check("rst_out_val", {32'd0, bus.out_val}, 64'd0);
        check("rst_out_loc", {32'd0, bus.out_loc}, 64'd0);
        check("rst_div_start", {63'd0, bus.div_start}, 64'd0);
        check("rst_div_abort", {63'd0, bus.div_abort}, 64'd0);
        check("rst_dividend", bus.div_dividend, 64'd0);
        check("rst_divisor", bus.div_divisor, 64'd0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) begin
            run_job(vecs[i], i + 1, $sformatf("vec%0d", i));
        end

        // Abort mid-WAIT; the core still returns done later and must be ignored.
        load(64'd1000, 64'd3);
        core_mode = 2;
        a0 = aborts_seen;
        pulse_ctrl(c_ctrl_start);
        tick(9);
        check("abort_pre_state", {61'd0, bus.state_reg[2:0]}, {61'd0, c_st_wait});
        bus.ctrl_reg[c_ctrl_abort] = 1'b1;
        tick();
        check("abort_state", {61'd0, bus.state_reg[2:0]}, {61'd0, c_st_idle});
        check("abort_pulse", {63'd0, bus.div_abort}, 64'd1);
        bus.ctrl_reg[c_ctrl_abort] = 1'b0;
        tick();
        check("abort_pulse_end", {63'd0, bus.div_abort}, 64'd0);
        tick(70);
        check("late_done_state", {61'd0, bus.state_reg[2:0]}, {61'd0, c_st_idle});
        check("late_done_jobs", {48'd0, bus.state_reg[31:16]}, 64'd5);
        check("late_done_flag", {63'd0, bus.state_reg[c_sr_done]}, 64'd0);
        check("abort_count", aborts_seen - a0, 64'd1);
        check("abort_dvd_kept", bus.div_dividend, 64'd1000);
        read_chunk(c_loc_q_lo, c);
        check("abort_q_kept", {32'd0, c}, 64'hFFFF_FFFF);
        core_mode = 0;

        // Timeout: the core never answers.
        load(64'd50, 64'd5);
        core_mode = 1;
        a0 = aborts_seen;
        pulse_ctrl(c_ctrl_start);
        n = 0;
        while (bus.state_reg[2:0] === c_st_wait && n < 400) begin
            n++;
            tick();
        end
        check("timeout_wait_cycles", n, TIMEOUT_CYC);
        check("timeout_state", {61'd0, bus.state_reg[2:0]}, {61'd0, c_st_err});
        check("timeout_abort", {63'd0, bus.div_abort}, 64'd1);
        check("timeout_flag", {63'd0, bus.state_reg[c_sr_timeout]}, 64'd1);
        tick();
        check("timeout_abort_end", {63'd0, bus.div_abort}, 64'd0);
        check("timeout_abort_count", aborts_seen - a0, 64'd1);
        read_chunk(c_loc_r_lo, c);
        check("timeout_r_kept", {32'd0, c}, 64'hFFFF_FFFF);

        // Busy write and start during WAIT, then reset mid-WAIT.
        load(64'd200, 64'd9);
        check("load_clears_timeout", {63'd0, bus.state_reg[c_sr_timeout]}, 64'd0);
        pulse_ctrl(c_ctrl_start);
        st0 = starts_seen;
        write_chunk(c_loc_dvd_lo, 32'hDEAD);
        check("busy_wr_ign", {63'd0, bus.state_reg[c_sr_wr_ign]}, 64'd1);
        check("busy_state", {61'd0, bus.state_reg[2:0]}, {61'd0, c_st_wait});
        check("busy_dvd", bus.div_dividend, 64'd200);
        check("busy_dvs", bus.div_divisor, 64'd9);
        pulse_ctrl(c_ctrl_start);
        check("busy_no_restart", starts_seen - st0, 64'd0);
        bus.in_loc = 32'h8;
        tick();
        check("pre_reset_out_loc", {32'd0, bus.out_loc}, 64'd2);
        reset = 1'b1;
        tick();
        check("mid_rst_state_reg", {32'd0, bus.state_reg}, 64'd0);
        check("mid_rst_out_val", {32'd0, bus.out_val}, 64'd0);
        check("mid_rst_out_loc", {32'd0, bus.out_loc}, 64'd0);
        check("mid_rst_dividend", bus.div_dividend, 64'd0);
        check("mid_rst_divisor", bus.div_divisor, 64'd0);
        check("mid_rst_abort", {63'd0, bus.div_abort}, 64'd0);
        reset = 1'b0;
        core_mode = 0;
        tick(2);

        run_job('{dvd: 64'd9, dvs: 64'd2, q: 64'd4, r: 64'd1, dbz: 1'b0}, 1, "post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
